// File: rtl/inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : inst_fetch_queue
//  Brief    : Decoupled instruction-fetch front end. Owns the fetch PC, keeps
//             one request outstanding to instruction memory, buffers returned
//             {pc, inst} pairs in a circular queue and handles redirects.
//  Revision : 1.0 - initial release
// ============================================================================
module inst_fetch_queue #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                           clk,
  input  logic                           cpu_rst_n,
  input  logic                           cpu_en,
  output logic                           inst_ren,
  output logic [ADDR_WIDTH-1:0]          inst_addr,
  input  logic                           inst_ack,
  input  logic [DATA_WIDTH-1:0]          inst_data,
  input  logic                           redirect_en,
  input  logic [ADDR_WIDTH-1:0]          redirect_pc,
  output logic                           if_valid,
  output logic [DATA_WIDTH-1:0]          if_inst,
  output logic [ADDR_WIDTH-1:0]          if_pc,
  input  logic                           if_ready,
  output logic [$clog2(DEPTH+1)-1:0]     queue_count
);

  localparam int                    c_PTR_W  = $clog2(DEPTH);
  localparam int                    c_CNT_W  = $clog2(DEPTH+1);
  localparam logic [ADDR_WIDTH-1:0] c_PC_INC = ADDR_WIDTH'(4);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_fpc;
  logic [ADDR_WIDTH-1:0]   r_req_addr;
  logic [ADDR_WIDTH-1:0]   w_fpc_nxt;
  logic [ADDR_WIDTH-1:0]   w_req_nxt;
  logic [ADDR_WIDTH-1:0]   w_enq_pc;
  logic [ADDR_WIDTH-1:0]   w_redir_pc;
  logic                    w_enq;
  logic                    w_pop;
  logic                    w_redir;
  logic                    w_busy;
  logic                    w_room;
  logic                    w_unused;

  logic [ADDR_WIDTH-1:0]   r_pc_q   [DEPTH];
  logic [DATA_WIDTH-1:0]   r_inst_q [DEPTH];
  logic [c_PTR_W-1:0]      r_rd_ptr;
  logic [c_PTR_W-1:0]      r_wr_ptr;
  logic [c_CNT_W-1:0]      r_count;

  // The low address bits of a redirect target are forced to a word boundary.
  assign w_redir_pc = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
  assign w_unused   = ^redirect_pc[1:0];

  // A redirect only takes effect while the CPU is enabled.
  assign w_redir = cpu_en & redirect_en;

  // An outstanding request already owns a queue slot for its return data.
  assign w_busy = (r_state != S_IDLE);
  assign w_room = ({1'b0, r_count} + (c_CNT_W+1)'(w_busy)) < (c_CNT_W+1)'(DEPTH);

  assign if_valid    = (r_count != '0) & cpu_en & ~redirect_en;
  assign w_pop       = if_valid & if_ready;
  assign if_inst     = r_inst_q[r_rd_ptr];
  assign if_pc       = r_pc_q[r_rd_ptr];
  assign queue_count = r_count;

  // Request FSM next-state, memory request outputs and enqueue decision.
  always_comb begin
    w_state_nxt = r_state;
    inst_ren    = 1'b0;
    inst_addr   = r_fpc;
    w_enq       = 1'b0;
    w_enq_pc    = r_fpc;
    w_fpc_nxt   = r_fpc;
    w_req_nxt   = r_req_addr;
    case (r_state)
      S_IDLE: begin
        inst_ren = cpu_en & w_room & ~redirect_en;
        if (inst_ren) begin
          w_req_nxt = r_fpc;
          if (inst_ack) begin
            w_enq     = 1'b1;
            w_fpc_nxt = r_fpc + c_PC_INC;
          end else begin
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        // Address is held until the memory answers, whatever cpu_en does.
        inst_ren  = 1'b1;
        inst_addr = r_req_addr;
        if (inst_ack) begin
          w_state_nxt = S_IDLE;
          if (!w_redir) begin
            w_enq     = 1'b1;
            w_enq_pc  = r_req_addr;
            w_fpc_nxt = r_req_addr + c_PC_INC;
          end
        end else if (w_redir) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        inst_ren  = 1'b1;
        inst_addr = r_req_addr;
        if (inst_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
    // Redirect target wins over any sequential PC update.
    if (w_redir) begin
      w_fpc_nxt = w_redir_pc;
    end
  end

  // Fetch PC, request address and FSM state registers.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      r_state    <= S_IDLE;
      r_fpc      <= RESET_PC;
      r_req_addr <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fpc      <= w_fpc_nxt;
      r_req_addr <= w_req_nxt;
    end
  end

  // Circular queue: storage, pointers and occupancy; redirect flushes it.
  always_ff @(posedge clk or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc_q[i]   <= '0;
        r_inst_q[i] <= '0;
      end
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (w_redir) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) begin
        r_pc_q[r_wr_ptr]   <= w_enq_pc;
        r_inst_q[r_wr_ptr] <= inst_data;
        r_wr_ptr           <= r_wr_ptr + c_PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      end
      case ({w_enq, w_pop})
        2'b10:   r_count <= r_count + c_CNT_W'(1);
        2'b01:   r_count <= r_count - c_CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_fetch_queue
//  Brief    : Self-checking bench for inst_fetch_queue with a variable-latency
//             memory model and a queue-based reference of the fetch stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_fetch_queue;

  localparam int c_DEPTH = 4;

  logic        clk = 1'b0;
  logic        cpu_rst_n;
  logic        cpu_en;
  logic        inst_ren;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_data;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_ready;
  logic [2:0]  queue_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state: fetch PC, queued PCs, outstanding request.
  logic [31:0] m_fpc;
  logic [31:0] m_q[$];
  bit          m_out;
  logic [31:0] m_out_addr;
  bit          m_drop;

  // Memory model state.
  bit mem_busy;
  int mem_cnt;
  int mem_lat;
  int fixed_lat;
  bit spurious;

  inst_fetch_queue #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (c_DEPTH),
    .RESET_PC   (32'h0)
  ) dut (
    .clk         (clk),
    .cpu_rst_n   (cpu_rst_n),
    .cpu_en      (cpu_en),
    .inst_ren    (inst_ren),
    .inst_addr   (inst_addr),
    .inst_ack    (inst_ack),
    .inst_data   (inst_data),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .if_valid    (if_valid),
    .if_inst     (if_inst),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .queue_count (queue_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_fpc    = 32'h0;
    m_q.delete();
    m_out    = 1'b0;
    m_drop   = 1'b0;
    mem_busy = 1'b0;
    mem_cnt  = 0;
  endtask

  task automatic check_reset_outputs(input string pfx);
    chk({pfx, "_ren"},   64'(inst_ren),    64'd0);
    chk({pfx, "_addr"},  64'(inst_addr),   64'd0);
    chk({pfx, "_valid"}, 64'(if_valid),    64'd0);
    chk({pfx, "_count"}, 64'(queue_count), 64'd0);
    chk({pfx, "_inst"},  64'(if_inst),     64'd0);
    chk({pfx, "_pc"},    64'(if_pc),       64'd0);
  endtask

  // One clock cycle: drive inputs, answer memory, compare, advance the model.
  task automatic step(input bit en, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          room, exp_ren, exp_valid, ack, redir, deliver;
    logic [31:0] exp_addr;
    @(negedge clk);
    cpu_en      = en;
    redirect_en = rd;
    redirect_pc = rpc;
    if_ready    = rdy;
    inst_ack    = 1'b0;
    #1;
    room      = (m_q.size() + int'(m_out)) < c_DEPTH;
    exp_ren   = m_out ? 1'b1 : (en & room & ~rd);
    exp_addr  = m_out ? m_out_addr : m_fpc;
    exp_valid = (m_q.size() != 0) && en && !rd;
    chk("inst_ren", 64'(inst_ren), 64'(exp_ren));
    if (exp_ren) chk("inst_addr", 64'(inst_addr), 64'(exp_addr));
    ack = 1'b0;
    if (inst_ren) begin
      if (!mem_busy) begin
        mem_busy = 1'b1;
        mem_cnt  = 0;
        mem_lat  = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
      ack = (mem_cnt >= mem_lat);
      inst_data = ack ? mem_f(inst_addr) : $urandom;
    end else begin
      ack = spurious && ($urandom_range(0, 3) == 0);
      inst_data = $urandom;
    end
    inst_ack = ack;
    #1;
    chk("if_valid", 64'(if_valid), 64'(exp_valid));
    chk("queue_count", 64'(queue_count), 64'(m_q.size()));
    if (exp_valid) begin
      chk("if_pc", 64'(if_pc), 64'(m_q[0]));
      chk("if_inst", 64'(if_inst), 64'(mem_f(m_q[0])));
    end
    @(posedge clk);
    if (inst_ren) begin
      if (ack) mem_busy = 1'b0;
      else     mem_cnt++;
    end
    redir = en && rd;
    if (exp_valid && rdy) void'(m_q.pop_front());
    if (m_out) begin
      if (ack) begin
        deliver = !m_drop && !redir;
        m_out   = 1'b0;
        m_drop  = 1'b0;
        if (deliver) begin
          m_q.push_back(m_out_addr);
          m_fpc = m_out_addr + 32'd4;
        end
      end else if (redir) begin
        m_drop = 1'b1;
      end
    end else if (exp_ren) begin
      if (ack) begin
        m_q.push_back(m_fpc);
        m_fpc = m_fpc + 32'd4;
      end else begin
        m_out      = 1'b1;
        m_out_addr = m_fpc;
      end
    end
    if (redir) begin
      m_q.delete();
      m_fpc = rpc & 32'hFFFF_FFFC;
    end
  endtask

  initial begin
    cpu_rst_n   = 1'b0;
    cpu_en      = 1'b0;
    inst_ack    = 1'b0;
    inst_data   = '0;
    redirect_en = 1'b0;
    redirect_pc = '0;
    if_ready    = 1'b0;
    fixed_lat   = 0;
    spurious    = 1'b0;
    model_reset();

    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    cpu_rst_n = 1'b1;

    // Zero-wait memory, decode always ready: one instruction per cycle.
    fixed_lat = 0;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Decode stalled: queue fills to DEPTH, then a single pop frees one slot.
    repeat (8) step(1'b1, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect with a full queue while decode is ready: flush, no pop.
    step(1'b1, 1'b1, 32'h0000_0040, 1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Latency 3 with a redirect while a request waits: data is discarded.
    fixed_lat = 3;
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0100, 1'b1);
    repeat (12) step(1'b1, 1'b0, 32'h0, 1'b1);

    // PC wrap at the top of the address space and a misaligned target.
    fixed_lat = 0;
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1);
    repeat (5) step(1'b1, 1'b0, 32'h0, 1'b1);
    step(1'b1, 1'b1, 32'h0000_0013, 1'b1);
    repeat (4) step(1'b1, 1'b0, 32'h0, 1'b1);

    // CPU disabled while the ack of an outstanding request arrives.
    fixed_lat = 2;
    repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
    repeat (5) step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);

    // Randomized traffic.
    fixed_lat = -1;
    spurious  = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 7) != 0), ($urandom_range(0, 9) == 0),
           $urandom, ($urandom_range(0, 2) != 0));
    end
    spurious = 1'b0;

    // Asynchronous reset while a long-latency request is outstanding.
    fixed_lat = 20;
    repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    cpu_en      = 1'b0;
    redirect_en = 1'b0;
    inst_ack    = 1'b0;
    #1;
    cpu_rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    @(posedge clk);
    @(negedge clk);
    cpu_rst_n = 1'b1;
    model_reset();
    fixed_lat = 0;
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
